// File: rtl/mcs8_int_pkg.sv
// Shared definitions for the MCS8 interrupt controller: widths, FSM states
// and a one-hot decode helper.
package mcs8_int_pkg;

  localparam int NUM_IRQ = 8;
  localparam int VEC_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
    return NUM_IRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/int_ctrl8_if.sv
// CPU-side bundle of the interrupt controller: request lines, mask access,
// acknowledge/EOI handshake and status read-back.
interface int_ctrl8_if;
  import mcs8_int_pkg::*;

  logic [NUM_IRQ-1:0] IrqIn;
  logic               MaskWe;
  logic [NUM_IRQ-1:0] MaskIn;
  logic               IntAck;
  logic               Eoi;
  logic               IntReq;
  logic [VEC_W-1:0]   Vector;
  logic               VectorValid;
  logic [NUM_IRQ-1:0] Mask;
  logic [NUM_IRQ-1:0] Pending;
  logic [NUM_IRQ-1:0] InService;

  modport master (
    output IrqIn, MaskWe, MaskIn, IntAck, Eoi,
    input  IntReq, Vector, VectorValid, Mask, Pending, InService
  );

  modport slave (
    input  IrqIn, MaskWe, MaskIn, IntAck, Eoi,
    output IntReq, Vector, VectorValid, Mask, Pending, InService
  );

endinterface

// File: rtl/int_ctrl8_prio_enc8.sv
// Fixed-priority encoder: returns the index of the lowest set bit of req
// and a flag telling whether any bit was set.
module prio_enc8
  import mcs8_int_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               vld
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = VEC_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl8.sv
// Eight-line interrupt controller: edge-latched requests, masking, fixed
// priority with in-service nesting, and an IntReq/IntAck/Eoi handshake.
module int_ctrl8
  import mcs8_int_pkg::*;
#(
  parameter logic [NUM_IRQ-1:0] RESET_MASK = 8'h00
) (
  input logic        Clk,
  input logic        Rst_n,
  int_ctrl8_if.slave bus
);

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic               armed_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] isr_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic               int_req_q;
  logic [VEC_W-1:0]   vector_q;
  logic               vector_valid_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [VEC_W-1:0]   win_idx;
  logic               win_vld;
  logic [VEC_W-1:0]   isr_idx;
  logic               isr_vld;
  logic               eligible;
  logic               go_ack;
  logic [NUM_IRQ-1:0] ack_bit;
  logic [NUM_IRQ-1:0] eoi_bit;

  // The first edge after reset only loads the edge register, so a line that
  // was already high during reset is not seen as a new request.
  assign rise = armed_q ? (bus.IrqIn & ~irq_q) : '0;
  assign cand = pending_q & ~mask_q;

  prio_enc8 u_win_enc (
    .req (cand),
    .idx (win_idx),
    .vld (win_vld)
  );

  // Lowest in-service level: both the EOI target and the nesting threshold.
  prio_enc8 u_isr_enc (
    .req (isr_q),
    .idx (isr_idx),
    .vld (isr_vld)
  );

  assign eligible = win_vld && (!isr_vld || (win_idx < isr_idx));
  assign go_ack   = (state_q == REQ) && bus.IntAck && eligible;
  assign ack_bit  = go_ack ? onehot(win_idx) : '0;
  assign eoi_bit  = (bus.Eoi && isr_vld) ? onehot(isr_idx) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (eligible) state_d = REQ;
      REQ: begin
        if (!eligible)       state_d = IDLE;
        else if (bus.IntAck) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      irq_q          <= '0;
      armed_q        <= 1'b0;
      pending_q      <= '0;
      isr_q          <= '0;
      mask_q         <= RESET_MASK;
      int_req_q      <= 1'b0;
      vector_q       <= '0;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      irq_q          <= bus.IrqIn;
      armed_q        <= 1'b1;
      // A fresh edge beats the acknowledge clear on the same line.
      pending_q      <= (pending_q & ~ack_bit) | rise;
      isr_q          <= (isr_q & ~eoi_bit) | ack_bit;
      int_req_q      <= (state_d == REQ);
      vector_valid_q <= (state_d == ACK);
      if (bus.MaskWe) mask_q   <= bus.MaskIn;
      if (go_ack)     vector_q <= win_idx;
    end
  end

  assign bus.IntReq      = int_req_q;
  assign bus.Vector      = vector_q;
  assign bus.VectorValid = vector_valid_q;
  assign bus.Mask        = mask_q;
  assign bus.Pending     = pending_q;
  assign bus.InService   = isr_q;

endmodule

// File: tb/tb_int_ctrl8.sv
// Directed bench for int_ctrl8: inputs change 1 ns after a rising edge and
// outputs are checked at that same point, after the edge has settled.
module tb_int_ctrl8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  int_ctrl8_if bus ();

  int_ctrl8 #(.RESET_MASK(8'h00)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.IrqIn      = 8'h00;
    bus.MaskWe     = 1'b0;
    bus.MaskIn     = 8'h00;
    bus.IntAck     = 1'b0;
    bus.Eoi        = 1'b0;

    // Reset state
    step(2);
    check("rst_intreq",  8'(bus.IntReq), 8'h00);
    check("rst_vector",  8'(bus.Vector), 8'h00);
    check("rst_vvalid",  8'(bus.VectorValid), 8'h00);
    check("rst_mask",    bus.Mask, 8'h00);
    check("rst_pending", bus.Pending, 8'h00);
    check("rst_isr",     bus.InService, 8'h00);
    rst_n = 1'b1;
    step(2);

    // Single request on line 5
    bus.IrqIn = 8'h20;
    step();
    check("single_pend",   bus.Pending, 8'h20);
    check("single_noreq",  8'(bus.IntReq), 8'h00);
    bus.IrqIn = 8'h00;
    step();
    check("single_req",    8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("single_vec",    8'(bus.Vector), 8'h05);
    check("single_vv",     8'(bus.VectorValid), 8'h01);
    check("single_isr",    bus.InService, 8'h20);
    check("single_pend0",  bus.Pending, 8'h00);
    check("single_reqlow", 8'(bus.IntReq), 8'h00);
    step();
    check("single_vv_end", 8'(bus.VectorValid), 8'h00);
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;
    check("single_eoi",    bus.InService, 8'h00);

    // Priority: lines 6 and 2 together
    bus.IrqIn = 8'h44;
    step();
    bus.IrqIn = 8'h00;
    check("prio_pend",   bus.Pending, 8'h44);
    step();
    check("prio_req1",   8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("prio_vec1",   8'(bus.Vector), 8'h02);
    check("prio_isr1",   bus.InService, 8'h04);
    step(2);
    check("prio_blocked", 8'(bus.IntReq), 8'h00);
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;
    step();
    check("prio_req2",   8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("prio_vec2",   8'(bus.Vector), 8'h06);
    check("prio_isr2",   bus.InService, 8'h40);
    step();
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;
    check("prio_clean",  bus.InService, 8'h00);

    // Nesting: line 4 in service, then line 1, then line 6
    bus.IrqIn = 8'h10;
    step();
    bus.IrqIn = 8'h00;
    step();
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("nest_isr4",   bus.InService, 8'h10);
    step();
    bus.IrqIn = 8'h02;
    step();
    bus.IrqIn = 8'h00;
    step();
    check("nest_req1",   8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("nest_vec1",   8'(bus.Vector), 8'h01);
    check("nest_isr12",  bus.InService, 8'h12);
    step();
    bus.IrqIn = 8'h40;
    step();
    bus.IrqIn = 8'h00;
    step();
    check("nest_no6",    8'(bus.IntReq), 8'h00);
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;
    check("nest_eoi1",   bus.InService, 8'h10);
    step();
    check("nest_still",  8'(bus.IntReq), 8'h00);
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;
    check("nest_eoi2",   bus.InService, 8'h00);
    step();
    check("nest_req6",   8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("nest_vec6",   8'(bus.Vector), 8'h06);
    step();
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;

    // Mask holds off line 3 until cleared
    bus.MaskWe = 1'b1;
    bus.MaskIn = 8'h08;
    step();
    bus.MaskWe = 1'b0;
    check("mask_val",    bus.Mask, 8'h08);
    bus.IrqIn = 8'h08;
    step();
    bus.IrqIn = 8'h00;
    check("mask_pend",   bus.Pending, 8'h08);
    step(2);
    check("mask_noreq",  8'(bus.IntReq), 8'h00);
    bus.MaskWe = 1'b1;
    bus.MaskIn = 8'h00;
    step();
    bus.MaskWe = 1'b0;
    check("mask_clr",    bus.Mask, 8'h00);
    check("mask_lag",    8'(bus.IntReq), 8'h00);
    step();
    check("mask_req",    8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("mask_vec",    8'(bus.Vector), 8'h03);
    step();
    bus.Eoi = 1'b1;
    step();
    bus.Eoi = 1'b0;

    // Withdrawal: masking line 0 while in REQ
    bus.IrqIn = 8'h01;
    step(2);
    check("wd_req",      8'(bus.IntReq), 8'h01);
    bus.MaskWe = 1'b1;
    bus.MaskIn = 8'h01;
    step();
    bus.MaskWe = 1'b0;
    step();
    check("wd_drop",     8'(bus.IntReq), 8'h00);
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    check("wd_novv",     8'(bus.VectorValid), 8'h00);
    check("wd_noisr",    bus.InService, 8'h00);
    check("wd_pend",     bus.Pending, 8'h01);

    // Reset mid-handshake, line 7 held high across release
    bus.MaskWe = 1'b1;
    bus.MaskIn = 8'h00;
    step();
    bus.MaskWe = 1'b0;
    step();
    check("rr_req",      8'(bus.IntReq), 8'h01);
    bus.IrqIn = 8'h80;
    rst_n     = 1'b0;
    #1;
    check("rr_intreq",   8'(bus.IntReq), 8'h00);
    check("rr_pend",     bus.Pending, 8'h00);
    check("rr_isr",      bus.InService, 8'h00);
    check("rr_vector",   8'(bus.Vector), 8'h00);
    check("rr_mask",     bus.Mask, 8'h00);
    step();
    rst_n = 1'b1;
    step(3);
    check("rr_hold_pend", bus.Pending, 8'h00);
    check("rr_hold_req",  8'(bus.IntReq), 8'h00);
    bus.IrqIn = 8'h00;
    step();

    // New edge on the line being acknowledged keeps it pending
    bus.IrqIn = 8'h04;
    step();
    bus.IrqIn = 8'h00;
    step();
    check("sw_req",      8'(bus.IntReq), 8'h01);
    bus.IrqIn  = 8'h04;
    bus.IntAck = 1'b1;
    step();
    bus.IntAck = 1'b0;
    bus.IrqIn  = 8'h00;
    check("sw_vec",      8'(bus.Vector), 8'h02);
    check("sw_isr",      bus.InService, 8'h04);
    check("sw_pend",     bus.Pending, 8'h04);
    step();

    // Acknowledge and EOI in the same cycle
    bus.IrqIn = 8'h01;
    step();
    bus.IrqIn = 8'h00;
    step();
    check("ae_req",      8'(bus.IntReq), 8'h01);
    bus.IntAck = 1'b1;
    bus.Eoi    = 1'b1;
    step();
    bus.IntAck = 1'b0;
    bus.Eoi    = 1'b0;
    check("ae_vec",      8'(bus.Vector), 8'h00);
    check("ae_isr",      bus.InService, 8'h01);
    check("ae_pend",     bus.Pending, 8'h04);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
